// File: rtl/writeback_stage_if.sv
// Bundle of the memory-stage inputs, data-bus read channel and register-file
// write port seen by the writeback stage.
//
//   m_*            instruction fields registered from the memory stage
//   dbus_rd_*      word-aligned read data and its valid strobe
//   w_*            register-file write port, stall, retire count, error flag
//   dbg_wait_load  1 while the stage's FSM is in WAIT_LOAD
//
// Modports:
//   master - the surrounding pipeline / bus (drives m_* and dbus_*)
//   slave  - the writeback stage (drives w_* and dbg_wait_load)
//
// Handshake: there is no valid/ready pair here. The memory stage presents an
// instruction every cycle (m_valid = 0 marks a bubble) and it is taken at a
// rising edge only when w_stall is 0 during that cycle; while w_stall is 1
// the memory stage must hold its outputs. dbus_rd_valid is a one-cycle
// strobe that the stage consumes only while a load is outstanding.
interface writeback_stage_if;
  logic        m_valid;
  logic [31:0] m_alu_result;
  logic [4:0]  m_rd;
  logic [31:0] m_pc_plus_4;
  logic        m_reg_write;
  logic [1:0]  m_result_src;
  logic [2:0]  m_load_funct3;
  logic [31:0] dbus_rd_data;
  logic        dbus_rd_valid;
  logic [31:0] w_result;
  logic [4:0]  w_rd;
  logic        w_reg_write;
  logic        w_stall;
  logic [31:0] w_retired;
  logic        w_load_err;
  logic        dbg_wait_load;

  modport master (
    output m_valid, m_alu_result, m_rd, m_pc_plus_4, m_reg_write,
           m_result_src, m_load_funct3, dbus_rd_data, dbus_rd_valid,
    input  w_result, w_rd, w_reg_write, w_stall, w_retired, w_load_err,
           dbg_wait_load
  );

  modport slave (
    input  m_valid, m_alu_result, m_rd, m_pc_plus_4, m_reg_write,
           m_result_src, m_load_funct3, dbus_rd_data, dbus_rd_valid,
    output w_result, w_rd, w_reg_write, w_stall, w_retired, w_load_err,
           dbg_wait_load
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback (W) stage of the 5-stage RV32I pipeline.
//
// Registers the memory-stage instruction, waits for variable-latency load
// data on the data-bus read channel, aligns and extends it, selects the
// writeback value and drives the register-file write port. While a load is
// outstanding the upstream pipeline is stalled; a load that sees no data for
// LOAD_TIMEOUT wait cycles is force-completed with result 0 and the sticky
// w_load_err flag set.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-low
//   bus    - writeback_stage_if.slave (m_*, dbus_*, w_*, dbg_wait_load)
//
// Parameter:
//   LOAD_TIMEOUT - wait cycles before a load is force-completed (1..255)
module writeback_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave bus
);

  localparam logic [7:0] TMAX = 8'(LOAD_TIMEOUT);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  tcount_q, tcount_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        reg_write_q, reg_write_d;
  logic [1:0]  src_q, src_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] retired_q, retired_d;
  logic        load_err_q, load_err_d;

  logic        completing;
  logic        timed_out;
  logic        capture_load;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] result;

  // Completion and load-data path
  always_comb begin
    // In IDLE the registered instruction always completes. In WAIT_LOAD it
    // completes on read data or once the wait budget is used up; data
    // arriving on the last budget cycle counts as a normal completion.
    completing = (state_q == IDLE) || bus.dbus_rd_valid || (tcount_q == TMAX);
    timed_out  = (state_q == WAIT_LOAD) && !bus.dbus_rd_valid && (tcount_q == TMAX);
    capture_load = bus.m_valid && (bus.m_result_src == 2'b01);

    byte_sel = 8'h00;
    case (off_q)
      2'd0:    byte_sel = bus.dbus_rd_data[7:0];
      2'd1:    byte_sel = bus.dbus_rd_data[15:8];
      2'd2:    byte_sel = bus.dbus_rd_data[23:16];
      default: byte_sel = bus.dbus_rd_data[31:24];
    endcase
    half_sel = off_q[1] ? bus.dbus_rd_data[31:16] : bus.dbus_rd_data[15:0];

    // Only data actually returned while waiting is used; a timed-out load
    // and every other cycle see 0.
    load_data = 32'h0;
    if ((state_q == WAIT_LOAD) && bus.dbus_rd_valid) begin
      case (funct3_q)
        3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
        3'b100:  load_data = {24'h0, byte_sel};
        3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
        3'b101:  load_data = {16'h0, half_sel};
        default: load_data = bus.dbus_rd_data;
      endcase
    end

    case (src_q)
      2'b01:   result = load_data;
      2'b10:   result = pc4_q;
      default: result = alu_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    tcount_d    = tcount_q;
    valid_d     = valid_q;
    alu_d       = alu_q;
    rd_d        = rd_q;
    pc4_d       = pc4_q;
    reg_write_d = reg_write_q;
    src_d       = src_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    retired_d   = retired_q + 32'(valid_q && completing);
    load_err_d  = load_err_q || timed_out;

    if (completing) begin
      // Completion and capture coincide: the next instruction is taken in
      // the same edge that retires the current one.
      valid_d     = bus.m_valid;
      alu_d       = bus.m_alu_result;
      rd_d        = bus.m_rd;
      pc4_d       = bus.m_pc_plus_4;
      reg_write_d = bus.m_reg_write;
      src_d       = bus.m_result_src;
      funct3_d    = bus.m_load_funct3;
      off_d       = bus.m_alu_result[1:0];
      state_d     = capture_load ? WAIT_LOAD : IDLE;
      tcount_d    = 8'h00;
    end else begin
      tcount_d    = tcount_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      tcount_q    <= 8'h00;
      valid_q     <= 1'b0;
      alu_q       <= 32'h0;
      rd_q        <= 5'd0;
      pc4_q       <= 32'h0;
      reg_write_q <= 1'b0;
      src_q       <= 2'b00;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      retired_q   <= 32'h0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcount_q    <= tcount_d;
      valid_q     <= valid_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      pc4_q       <= pc4_d;
      reg_write_q <= reg_write_d;
      src_q       <= src_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      retired_q   <= retired_d;
      load_err_q  <= load_err_d;
    end
  end

  assign bus.w_result      = result;
  assign bus.w_rd          = rd_q;
  assign bus.w_reg_write   = valid_q && reg_write_q && (rd_q != 5'd0) && completing;
  assign bus.w_stall       = !completing;
  assign bus.w_retired     = retired_q;
  assign bus.w_load_err    = load_err_q;
  assign bus.dbg_wait_load = (state_q == WAIT_LOAD);

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage. The driver issues instructions and, from a
// plain reference model, pushes the expected register-file writes and the
// expected retire-counter values into queues; a monitor pops and compares
// whenever the stage writes or retires.
module tb_writeback_stage;

  localparam int unsigned T = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  writeback_stage_if bus();

  writeback_stage #(.LOAD_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [36:0] exp_q[$];   // {rd, data} of each expected write
  logic [32:0] ret_q[$];   // {load_err, retired} after each retirement
  logic [31:0] model_retired = 32'h0;
  logic        model_err = 1'b0;
  logic [31:0] last_ret = 32'h0;
  logic        seen_err = 1'b0;

  // Driver's view of the outstanding load
  bit          pend_active = 1'b0;
  int          pend_age = 0;
  int          pend_lat = 0;
  logic [31:0] pend_data = 32'h0;

  task automatic report();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: load value from the byte address and returned word.
  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] data);
    logic [31:0] b;
    logic [31:0] h;
    b = (data >> (8 * addr[1:0])) & 32'hFF;
    h = (data >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return data;
    endcase
  endfunction

  // Driver: present one instruction until it is accepted. lat is the cycle
  // after capture at which load data returns; 0 means it never returns.
  task automatic issue(input logic v, input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [4:0] rd, input logic rw,
                       input logic [31:0] pc4, input int lat, input logic [31:0] ld_data);
    bit          accepted;
    logic [31:0] res;
    accepted = 1'b0;
    while (!accepted) begin
      bus.m_valid       = v;
      bus.m_result_src  = src;
      bus.m_load_funct3 = f3;
      bus.m_alu_result  = addr;
      bus.m_rd          = rd;
      bus.m_reg_write   = rw;
      bus.m_pc_plus_4   = pc4;
      if (pend_active) begin
        pend_age++;
        bus.dbus_rd_valid = (pend_lat != 0) && (pend_age == pend_lat);
        bus.dbus_rd_data  = bus.dbus_rd_valid ? pend_data : $urandom;
      end else begin
        // Stray strobes while nothing is outstanding must be ignored.
        bus.dbus_rd_valid = ($urandom_range(0, 3) == 0);
        bus.dbus_rd_data  = $urandom;
      end
      #1;
      if (!bus.w_stall) begin
        accepted = 1'b1;
        if (pend_active)
          check("load_stall_cycles", 64'(pend_age - 1), (pend_lat == 0) ? 64'(T) : 64'(pend_lat - 1));
        pend_active = 1'b0;
        if (v) begin
          if (src == 2'b01) res = (lat == 0) ? 32'h0 : load_value(f3, addr, ld_data);
          else if (src == 2'b10) res = pc4;
          else res = addr;
          model_retired = model_retired + 32'd1;
          if (src == 2'b01 && lat == 0) model_err = 1'b1;
          ret_q.push_back({model_err, model_retired});
          if (rw && rd != 5'd0) exp_q.push_back({rd, res});
          if (src == 2'b01) begin
            pend_active = 1'b1;
            pend_age    = 0;
            pend_lat    = lat;
            pend_data   = ld_data;
          end
        end
      end else if (!pend_active || pend_age >= int'(T) + 1) begin
        n_checks++;
        n_fail++;
        $display("FAIL stall_bound: stall=1 at load age %0d, required 0", pend_age);
        report();
      end
      @(negedge clk);
    end
  endtask

  task automatic bubble();
    issue(1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom,
          5'($urandom_range(0, 31)), 1'b1, $urandom, 0, 32'h0);
  endtask

  task automatic drain();
    while (pend_active) bubble();
    repeat (2) bubble();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    bus.m_valid = 1'b0;
    bus.dbus_rd_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    exp_q.delete();
    ret_q.delete();
    model_retired = 32'h0;
    model_err     = 1'b0;
    last_ret      = 32'h0;
    seen_err      = 1'b0;
    pend_active   = 1'b0;
    #1;
    check("reset_w_result", bus.w_result, 0);
    check("reset_w_rd", bus.w_rd, 0);
    check("reset_w_reg_write", bus.w_reg_write, 0);
    check("reset_w_stall", bus.w_stall, 0);
    check("reset_w_retired", bus.w_retired, 0);
    check("reset_w_load_err", bus.w_load_err, 0);
    check("reset_state_idle", bus.dbg_wait_load, 0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: compare every write and every retirement against the queues.
  initial begin
    logic [36:0] e;
    logic [32:0] r;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        if (bus.w_reg_write) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: rd %0d data %0h, required no write", bus.w_rd, bus.w_result);
          end else begin
            e = exp_q.pop_front();
            check("write_rd", bus.w_rd, e[36:32]);
            check("write_data", bus.w_result, e[31:0]);
          end
        end
        if (bus.w_retired !== last_ret) begin
          last_ret = bus.w_retired;
          if (ret_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_retire: w_retired %0h, required no change", bus.w_retired);
          end else begin
            r = ret_q.pop_front();
            seen_err = r[32];
            check("retired_count", bus.w_retired, r[31:0]);
          end
        end
        check("load_err_flag", bus.w_load_err, seen_err);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    report();
  end

  // Stimulus
  initial begin
    bus.m_valid = 1'b0;
    bus.m_alu_result = 32'h0;
    bus.m_rd = 5'd0;
    bus.m_pc_plus_4 = 32'h0;
    bus.m_reg_write = 1'b0;
    bus.m_result_src = 2'b00;
    bus.m_load_funct3 = 3'b000;
    bus.dbus_rd_data = 32'h0;
    bus.dbus_rd_valid = 1'b0;
    @(negedge clk);
    do_reset(2);

    // Directed: ALU, loads with latency, back-to-back, rd=0, bubbles
    issue(1'b1, 2'b00, 3'b000, 32'h1234, 5'd5, 1'b1, 32'h0, 0, 32'h0);
    issue(1'b1, 2'b01, 3'b000, 32'h103, 5'd7, 1'b1, 32'h0, 3, 32'h80FF_FF7F);
    issue(1'b1, 2'b01, 3'b100, 32'h103, 5'd8, 1'b1, 32'h0, 3, 32'h80FF_FF7F);
    issue(1'b1, 2'b01, 3'b001, 32'h102, 5'd9, 1'b1, 32'h0, 2, 32'h80FF_FF7F);
    issue(1'b1, 2'b01, 3'b010, 32'h100, 5'd10, 1'b1, 32'h0, 1, 32'hDEAD_BEEF);
    issue(1'b1, 2'b10, 3'b000, 32'h55, 5'd1, 1'b1, 32'h40, 0, 32'h0);
    issue(1'b1, 2'b00, 3'b000, 32'h99, 5'd0, 1'b1, 32'h0, 0, 32'h0);
    issue(1'b0, 2'b00, 3'b000, 32'h77, 5'd3, 1'b1, 32'h0, 0, 32'h0);
    issue(1'b0, 2'b01, 3'b000, 32'h78, 5'd3, 1'b1, 32'h0, 0, 32'h0);
    issue(1'b1, 2'b11, 3'b000, 32'hABC, 5'd4, 1'b1, 32'h10, 0, 32'h0);
    issue(1'b1, 2'b01, 3'b101, 32'h101, 5'd12, 1'b1, 32'h0, 2, 32'h8765_4321);
    issue(1'b1, 2'b01, 3'b011, 32'h103, 5'd13, 1'b1, 32'h0, 4, 32'hCAFE_F00D);
    issue(1'b1, 2'b01, 3'b000, 32'h104, 5'd14, 1'b0, 32'h0, 1, 32'h0000_0080);
    drain();

    // Timeout: data never returns, error sticks
    issue(1'b1, 2'b01, 3'b000, 32'h200, 5'd6, 1'b1, 32'h0, 0, 32'h0);
    issue(1'b1, 2'b00, 3'b000, 32'h5A5A, 5'd2, 1'b1, 32'h0, 0, 32'h0);
    drain();

    // Reset while waiting for a load: abandoned, no write
    issue(1'b1, 2'b01, 3'b010, 32'h300, 5'd11, 1'b1, 32'h0, 0, 32'h0);
    bus.m_valid = 1'b0;
    bus.dbus_rd_valid = 1'b0;
    repeat (2) begin
      #1;
      check("wait_stall", bus.w_stall, 1);
      @(negedge clk);
    end
    do_reset(1);
    issue(1'b1, 2'b00, 3'b000, 32'h1111, 5'd20, 1'b1, 32'h0, 0, 32'h0);
    issue(1'b1, 2'b10, 3'b000, 32'h2222, 5'd21, 1'b1, 32'h44, 0, 32'h0);
    drain();

    // Retire-counter wrap from a preloaded value
    #5;
    force dut.retired_q = 32'hFFFF_FFFE;
    #1;
    release dut.retired_q;
    model_retired = 32'hFFFF_FFFE;
    last_ret      = 32'hFFFF_FFFE;
    @(negedge clk);
    issue(1'b1, 2'b00, 3'b000, 32'h3333, 5'd22, 1'b1, 32'h0, 0, 32'h0);
    issue(1'b1, 2'b00, 3'b000, 32'h4444, 5'd0, 1'b1, 32'h0, 0, 32'h0);
    drain();

    // Randomized traffic
    repeat (400) begin
      logic [1:0] src;
      int         lat;
      src = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T));
      issue(($urandom_range(0, 7) != 0), src, 3'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, lat, $urandom);
    end
    drain();
    repeat (3) @(negedge clk);

    check("writes_outstanding", exp_q.size(), 0);
    check("retires_outstanding", ret_q.size(), 0);
    report();
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (W) stage of the 5-stage RV32I pipeline, directly downstream of the memory stage.
- Registers the memory-stage outputs and collects load data from the data bus read channel, which has variable latency.
- Aligns and sign/zero-extends load data, selects the writeback result, and drives the register-file write port.
- Stalls the upstream pipeline while a load is outstanding; also keeps a retired-instruction counter and a load-timeout error flag.

Parameters:
- LOAD_TIMEOUT, 16: maximum number of cycles spent in WAIT_LOAD before the load is force-completed with an error. Legal range is 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0, sampled on rising edge of clk.
- m_valid  in  1  memory stage holds a real instruction (not a bubble).
- m_alu_result  in  32  ALU result; for loads, this is the byte address.
- m_rd  in  5  destination register.
- m_pc_plus_4  in  32  link value for jal/jalr.
- m_reg_write  in  1  instruction writes rd.
- m_result_src  in  2  result select: 00 = ALU, 01 = load, 10 = pc+4, 11 = reserved (treated as ALU).
- m_load_funct3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes treated as lw.
- dbus_rd_data  in  32  word-aligned read data.
- dbus_rd_valid  in  1  dbus_rd_data valid this cycle.
- w_result  out  32  register-file write data.
- w_rd  out  5  register-file write address.
- w_reg_write  out  1  register-file write enable; write occurs at the rising edge ending the cycle.
- w_stall  out  1  hold the memory stage and all earlier stages.
- w_retired  out  32  count of completed valid instructions.
- w_load_err  out  1  sticky load-timeout flag.

Behaviour:
- Reset (reset == 0 at an edge): state = IDLE; all pipeline registers = 0; w_retired = 0; w_load_err = 0; timeout counter = 0.
  - Resulting outputs: w_result = 0, w_rd = 0, w_reg_write = 0, w_stall = 0.
  - Reset mid-WAIT_LOAD abandons the load with no register-file write.
- Capture: at an edge where reset == 1 and w_stall == 0, register all m_* inputs plus m_alu_result[1:0] as the byte offset. While w_stall == 1, the W registers hold.
- FSM, two states:
  - IDLE: the registered instruction completes this cycle. Next state is WAIT_LOAD if the capture at this edge is a valid load (m_valid & m_result_src == 01); otherwise IDLE.
  - WAIT_LOAD: w_stall = ~dbus_rd_valid & (tcount != LOAD_TIMEOUT).
    - Completes in the cycle where dbus_rd_valid == 1, or where the timeout counter tcount == LOAD_TIMEOUT.
    - On completion: next state is WAIT_LOAD if a new valid load is captured, else IDLE.
    - tcount increments each WAIT_LOAD cycle that does not complete; it clears on entry to WAIT_LOAD.
- In IDLE, dbus_rd_valid is ignored.
- Load data is used combinationally in the completion cycle; there is no extra latency. Minimum load latency is therefore 1 cycle after capture.
- Load extraction, with off = offset:
  - lb/lbu: byte off; sign- or zero-extend to 32 bits.
  - lh/lhu: half selected by off[1]; off[0] ignored; sign- or zero-extend.
  - lw: full word; off ignored.
- Timeout completion: load result = 0 and w_load_err set to 1. The register-file write still occurs, so the pipeline drains. w_load_err clears only on reset.
- w_result by result_src: 00/11 → ALU result, 01 → extended load data, 10 → pc_plus_4. Load result in non-completion cycles is don't-care (drive 0).
- w_reg_write = valid & reg_write & (rd != 0) & completing.
  - rd == 0 never writes.
  - Bubbles (valid == 0) never write or retire.
- w_retired increments by 1 at each edge where a valid instruction completes, whether or not it writes. Wraps from 0xFFFFFFFF to 0.
- Simultaneous completion and capture in the same cycle is the normal case; the back-to-back throughput is 1 instruction per cycle for non-loads.

Test Plan:
- Reset and ALU result: hold reset = 0 for 2 cycles → all outputs 0. Release; present ALU op with alu_result 0x1234, rd = 5 → next cycle w_result = 0x1234, w_rd = 5, w_reg_write = 1, w_retired = 1.
- Load with latency: lb at addr 0x103; dbus_rd_data = 0x80FF_FF7F arrives 3 cycles later → w_stall = 1 for 2 cycles, then w_result = 0xFFFF_FF80, write pulses once. Repeat as lbu → 0x0000_0080. lh at addr 0x102 → 0xFFFF_80FF.
- Back-to-back: lw at 0x100 (data valid the next cycle, 0xDEADBEEF) followed immediately by jal rd = 1, pc_plus_4 = 0x40 → consecutive writes 0xDEADBEEF then 0x40, no stall cycles.
- rd = 0 and bubbles: ALU op with rd = 0 → w_reg_write stays 0, w_retired increments. m_valid = 0 → no write, no increment.
- Timeout: LOAD_TIMEOUT = 4, dbus_rd_valid never asserted → w_stall high for 4 cycles, then a write of 0 to rd, w_load_err = 1 and sticky until reset. Assert reset mid-WAIT_LOAD in a second run → no write, state IDLE, w_load_err = 0.
- Counter wrap: force w_retired near 0xFFFFFFFF via 2 retirements from preload (or long run) → w_retired = 0xFFFFFFFF then 0x00000000.
